// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO: default word/pointer widths,
// the storage depth and the width of the occupancy counter.
package fifo_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEPTH      = 1 << DEF_ADDR_W;
  localparam int CNT_W      = DEF_ADDR_W + 1;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for sync_fifo: one write port and one synchronous
// read port whose output register is the FIFO's dout. The array itself is
// never reset; only the read data register clears on reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [(1<<ADDR_W)];

  // Store the incoming word; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read: rdata only moves on an accepted read or on reset.
  // A read and write to the same slot returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: 16 x 16 single-clock FIFO with registered read data and
// visible read/write pointers.
// Optional build macro FIFO_STATUS_EN appends full, empty and count outputs.
//
// Strobe semantics: wr and rd are single-cycle requests sampled on every
// rising edge; there is no back-pressure. A write is accepted when the FIFO
// is not full, or when it is full and a read is accepted in the same cycle.
// A read is accepted when the FIFO is not empty. Rejected requests are
// dropped with no state change. Reset overrides both strobes.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] wrptr,
  output logic [ADDR_W-1:0] rdptr
`ifdef FIFO_STATUS_EN
  ,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
`endif
);

`ifndef FIFO_STATUS_EN
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
`endif

  // Count value meaning "every slot occupied" (only the MSB set).
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic wr_ok;
  logic rd_ok;

  // Occupancy flags come straight from the registered count, so full and
  // empty stay unambiguous when the pointers coincide.
  always_comb begin
    full  = (count == FULL_CNT);
    empty = (count == '0);
    rd_ok = rd && !empty;
    wr_ok = wr && (!full || rd_ok);
  end

  // Pointer and occupancy bookkeeping for accepted accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrptr <= '0;
      rdptr <= '0;
      count <= '0;
    end else begin
      if (wr_ok) begin
        wrptr <= wrptr + 1'b1;
      end
      if (rd_ok) begin
        rdptr <= rdptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok && !rst),
    .waddr (wrptr),
    .wdata (din),
    .re    (rd_ok && !rst),
    .raddr (rdptr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo. Each driven cycle pushes the expected
// {phase, dout, wrptr, rdptr} into exp_q; a monitor on the falling edge pops
// and compares against what the FIFO presents after the rising edge.
module tb_sync_fifo;

  logic        clk;
  logic        rst;
  logic        wr;
  logic        rd;
  logic [15:0] din;
  logic [15:0] dout;
  logic [3:0]  wrptr;
  logic [3:0]  rdptr;
`ifdef FIFO_STATUS_EN
  logic        full;
  logic        empty;
  logic [4:0]  count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  logic [31:0] e;

  sync_fifo dut (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .rd    (rd),
    .din   (din),
    .dout  (dout),
    .wrptr (wrptr),
    .rdptr (rdptr)
`ifdef FIFO_STATUS_EN
    ,
    .full  (full),
    .empty (empty),
    .count (count)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog expired");
  end

  function automatic string phase_name(input logic [7:0] ph);
    case (ph)
      8'd1:    phase_name = "reset";
      8'd2:    phase_name = "single";
      8'd3:    phase_name = "overflow_wr";
      8'd4:    phase_name = "overflow_rd";
      8'd5:    phase_name = "underflow";
      8'd6:    phase_name = "wrap";
      8'd7:    phase_name = "simul_full";
      8'd8:    phase_name = "drain_full";
      8'd9:    phase_name = "simul_empty";
      8'd10:   phase_name = "midop_reset";
      default: phase_name = "misc";
    endcase
  endfunction

  // Driver: apply one cycle of strobes and queue the state expected after
  // the edge that samples them.
  task automatic step(input logic r, input logic w, input logic d,
                      input logic [15:0] di, input logic [7:0] ph,
                      input logic [15:0] edout, input logic [3:0] ewp,
                      input logic [3:0] erp);
    rst = r;
    wr  = w;
    rd  = d;
    din = di;
    @(posedge clk);
    exp_q.push_back({ph, edout, ewp, erp});
    #1;
    rst = 1'b0;
    wr  = 1'b0;
    rd  = 1'b0;
    din = 16'(16'h0000 + $urandom_range(0, 16'hFFFF));
  endtask

  // Scoreboard monitor: compare every queued expectation on the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({dout, wrptr, rdptr} !== e[23:0]) begin
        miscompares++;
        $display("FAIL %s: got dout=%h wrptr=%0d rdptr=%0d, expected dout=%h wrptr=%0d rdptr=%0d",
                 phase_name(e[31:24]), dout, wrptr, rdptr, e[23:8], e[7:4], e[3:0]);
      end
    end
  end

  initial begin
    rst = 1'b0;
    wr  = 1'b0;
    rd  = 1'b0;
    din = 16'h0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with a concurrent write: nothing stored, then a read is dropped.
    step(1, 1, 0, 16'hBEEF, 8'd1, 16'h0000, 4'd0, 4'd0);
    step(0, 0, 1, 16'h0000, 8'd1, 16'h0000, 4'd0, 4'd0);

    // Single write then read.
    step(0, 1, 0, 16'h1234, 8'd2, 16'h0000, 4'd1, 4'd0);
    step(0, 0, 1, 16'h0000, 8'd2, 16'h1234, 4'd1, 4'd1);

    // Overflow: 18 isolated writes of 1..18, then 18 reads.
    step(1, 0, 0, 16'h0000, 8'd1, 16'h0000, 4'd0, 4'd0);
    for (int i = 1; i <= 18; i++) begin
      step(0, 1, 0, 16'(i), 8'd3, 16'h0000, (i >= 16) ? 4'd0 : 4'(i), 4'd0);
      step(0, 0, 0, 16'h0000, 8'd3, 16'h0000, (i >= 16) ? 4'd0 : 4'(i), 4'd0);
    end
    for (int i = 1; i <= 18; i++) begin
      step(0, 0, 1, 16'h0000, 8'd4, (i >= 16) ? 16'd16 : 16'(i), 4'd0,
           (i >= 16) ? 4'd0 : 4'(i));
    end

    // Underflow from reset.
    step(1, 0, 0, 16'h0000, 8'd1, 16'h0000, 4'd0, 4'd0);
    step(0, 0, 1, 16'h0000, 8'd5, 16'h0000, 4'd0, 4'd0);
    step(0, 0, 1, 16'h0000, 8'd5, 16'h0000, 4'd0, 4'd0);

    // Wrap-around: 20 write/read pairs with values 100..119.
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 16'(100 + i), 8'd6, (i == 0) ? 16'h0000 : 16'(99 + i),
           4'((i + 1) % 16), 4'(i % 16));
      step(0, 0, 1, 16'h0000, 8'd6, 16'(100 + i), 4'((i + 1) % 16), 4'((i + 1) % 16));
    end

    // Simultaneous access when full.
    step(1, 0, 0, 16'h0000, 8'd1, 16'h0000, 4'd0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 16'(16'h0A00 + i), 8'd7, 16'h0000, 4'((i + 1) % 16), 4'd0);
    end
    step(0, 1, 1, 16'hAAAA, 8'd7, 16'h0A00, 4'd1, 4'd1);
    // Still full: a lone write is dropped.
    step(0, 1, 0, 16'h5A5A, 8'd7, 16'h0A00, 4'd1, 4'd1);
    for (int k = 1; k <= 16; k++) begin
      step(0, 0, 1, 16'h0000, 8'd8, (k == 16) ? 16'hAAAA : 16'(16'h0A00 + k),
           4'd1, 4'((1 + k) % 16));
    end
    step(0, 0, 1, 16'h0000, 8'd8, 16'hAAAA, 4'd1, 4'd1);

    // Simultaneous access when empty: only the write lands.
    step(1, 0, 0, 16'h0000, 8'd1, 16'h0000, 4'd0, 4'd0);
    step(0, 1, 1, 16'h5555, 8'd9, 16'h0000, 4'd1, 4'd0);
    step(0, 0, 1, 16'h0000, 8'd9, 16'h5555, 4'd1, 4'd1);

    // Reset mid-operation discards stored words.
    step(0, 1, 0, 16'h7777, 8'd10, 16'h5555, 4'd2, 4'd1);
    step(0, 1, 0, 16'h8888, 8'd10, 16'h5555, 4'd3, 4'd1);
    step(1, 0, 1, 16'h0000, 8'd10, 16'h0000, 4'd0, 4'd0);
    step(0, 0, 1, 16'h0000, 8'd10, 16'h0000, 4'd0, 4'd0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, 16-entry × 16-bit first-in/first-out buffer with registered read data and exposed read/write pointers. It decouples a producer issuing single-cycle write strobes from a consumer issuing single-cycle read strobes in the same clock domain. Writes to a full FIFO and reads from an empty FIFO are dropped without corrupting state.

## Interface
- DATA_W, 16, data word width.
- ADDR_W, 4, pointer width; depth = 2**ADDR_W = 16.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset; **synchronous, active-high** (one clock; reset is synchronous and active-high).
- wr  input  1  write request; sampled each rising edge.
- rd  input  1  read request; sampled each rising edge.
- din  input  DATA_W  write data; captured with an accepted write.
- dout  output  DATA_W  registered read data.
- wrptr  output  ADDR_W  current write pointer: the next slot to be written.
- rdptr  output  ADDR_W  current read pointer: the next slot to be read.
- Port order: clk, rst, wr, rd, din, dout, wrptr, rdptr.

## Operation
- Storage: 16 words. An internal occupancy counter `count` is ADDR_W+1 bits wide (0..16).
- full = (count == 16); empty = (count == 0).
- Accepted write: wr && !full, or wr && rd && full. On an accepted write:
  - mem[wrptr] <= din
  - wrptr <= wrptr + 1, modulo 16
- Accepted read: rd && !empty. On an accepted read:
  - dout <= mem[rdptr]
  - rdptr <= rdptr + 1, modulo 16
- Count update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged when both or neither are accepted.
- Rejected write (full, no read): memory, wrptr and count are unchanged; din is discarded.
- Rejected read (empty): rdptr and count are unchanged; dout holds its previous value.
- Simultaneous rd and wr:
  - Empty: only the write is accepted. Data is not forwarded to dout.
  - Full: both are accepted. The read returns the oldest word; the write fills the freed slot.
  - Otherwise: both are accepted.
- dout changes only on an accepted read or on reset.
- Memory contents are not reset.
- Pointers wrap naturally from 15 to 0. Full versus empty is resolved by count, not by pointer comparison.

## Timing
- Reset: when rst=1 at a rising edge, wrptr=0, rdptr=0, count=0 and dout=0 after that edge. Reset overrides any rd/wr in the same cycle. Reset mid-operation discards all stored data.
- Write latency: a word written at edge N is readable by a read request sampled at edge N+1.
- Read latency: dout is valid one cycle after the rd sample, i.e. immediately after the edge that accepts the read.
- Pointer outputs are registered and update on the same edge as the accepted access.
- No handshake back to the producer or consumer. Strobes may be held for multiple cycles; each high cycle is one request.

## Configuration
- FIFO_STATUS_EN defined: three extra outputs are appended after rdptr:
  - full (1 bit)
  - empty (1 bit)
  - count (ADDR_W+1 bits)
  
  Reset values are full=0, empty=1, count=0. All three are registered or derived combinationally from registered count.
- FIFO_STATUS_EN undefined: these ports do not exist. Internal full/empty logic is unchanged.

## Structure
- Package fifo_pkg: DATA_W and ADDR_W defaults, DEPTH constant, count width constant.
- Sub-module fifo_mem: 16×DATA_W register array with one write port (we, waddr, wdata) and one synchronous read port (re, raddr, rdata → dout register).
- Top level holds the pointers, count and accept logic.

## Test plan
- Reset:
  - Drive rst=1 for one edge with wr=1 and din=16'hBEEF → dout=0, wrptr=0, rdptr=0; nothing is stored.
- Single write/read:
  - Write 16'h1234 → wrptr=1.
  - Read one cycle later → dout=16'h1234 after that edge, rdptr=1.
- Overflow:
  - 18 isolated writes of values 1..18 → wrptr=0 after 16 writes and stays 0; writes 17 and 18 are dropped.
  - 18 reads → dout returns 1..16 in order; reads 17 and 18 leave dout=16 and rdptr=0.
- Underflow:
  - From reset, pulse rd=1 → rdptr stays 0, dout stays 0.
- Wrap-around:
  - Write/read pairs 20 times with values 100..119 → each read returns its matching value.
  - Pointers pass 15→0 and both end at 4.
- Simultaneous access:
  - Fill 16 words, then rd=wr=1 with din=16'hAAAA → dout=first word; both pointers advance; count remains 16.
  - From empty, rd=wr=1 → only the write is accepted; wrptr=1, rdptr=0.
